// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter
//   Round-robin arbiter that shares one 3-to-8 decoder among 8 requesters.
//   The decoder is driven by sel/en, and grant is the matching one-hot vector.
//   Each tenure is capped at MAX_HOLD cycles. Every release is followed by
//   one mandatory dead cycle before the next grant.
//
// Ports
//   clk      system clock; all state changes happen on its rising edge
//   reset_n  synchronous active-low reset
//   req      level-sensitive requests; bit i belongs to requester i
//   sel      index of the current grantee (decoder select)
//   en       grant valid (decoder enable)
//   grant    one-hot grant; equals 1<<sel while en=1, otherwise 0
//   busy     high while a tenure is in progress
//   timeout  one-cycle pulse during the dead cycle that follows a forced release
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no grantee; arbitrate on any request
// GRANT   | sel owns the decoder; hold_cnt counts cycles already held
// RELEASE | one dead cycle with en=0; arbitrate using the advanced ptr
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       en,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic [2:0] winner;
  logic       any_req;
  logic [2:0] scan_idx;

  // The scan walks from the farthest offset down to ptr itself. Because the
  // last match found wins, the result is the requester closest to ptr in
  // round-robin order.
  always_comb begin
    winner   = 3'd0;
    scan_idx = 3'd0;
    any_req  = |req;
    for (int i = 7; i >= 0; i--) begin
      scan_idx = ptr + 3'(i);
      if (req[scan_idx]) winner = scan_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      sel      <= 3'd0;
      en       <= 1'b0;
      grant    <= 8'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 3'd0;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          timeout <= 1'b0;
          if (any_req) begin
            state    <= GRANT;
            sel      <= winner;
            en       <= 1'b1;
            grant    <= 8'd1 << winner;
            busy     <= 1'b1;
            hold_cnt <= 8'd0;
          end else begin
            state <= IDLE;
          end
        end

        GRANT: begin
          // A dropped request takes precedence over the hold limit, so a
          // drop that coincides with the limit counts as a normal release.
          if (!req[sel] || (hold_cnt == 8'(MAX_HOLD - 1))) begin
            state   <= RELEASE;
            timeout <= req[sel];
            ptr     <= sel + 3'd1;
            en      <= 1'b0;
            grant   <= 8'd0;
            busy    <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        default: begin
          state   <= IDLE;
          en      <= 1'b0;
          grant   <= 8'd0;
          busy    <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule
